// File: rtl/axi_lite_reg_master_if.sv
// AXI4-Lite bus bundle between a register master and its slave.
// Master drives address/data/valid and the response readies; slave drives the rest.
interface axi_lite_reg_master_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [ADDR_WIDTH-1:0]     awaddr;
  logic [2:0]                awprot;
  logic                      wvalid;
  logic                      wready;
  logic [DATA_WIDTH-1:0]     wdata;
  logic [DATA_WIDTH/8-1:0]   wstrb;
  logic                      bvalid;
  logic                      bready;
  logic [1:0]                bresp;
  logic                      arvalid;
  logic                      arready;
  logic [ADDR_WIDTH-1:0]     araddr;
  logic [2:0]                arprot;
  logic                      rvalid;
  logic                      rready;
  logic [DATA_WIDTH-1:0]     rdata;
  logic [1:0]                rresp;

  modport master (
    output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    output arvalid, araddr, arprot, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
    input  arvalid, araddr, arprot, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi_lite_reg_master.sv
// AXI4-Lite register master: one valid/ready command becomes one single-beat
// write or read, with a registered response and a sticky stall-timeout flag.
module axi_lite_reg_master #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    axi_aclk,
  input  logic                    axi_resetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    timeout,
  input  logic                    timeout_clr,
  axi_lite_reg_master_if.master   m_axi_lite
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned CntWidth  =
      (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax = CntWidth'(TIMEOUT_CYCLES);
  localparam logic [CntWidth-1:0] CntSet = CntMax - CntWidth'(1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWr   = 3'd1;
  localparam logic [2:0] StWrB  = 3'd2;
  localparam logic [2:0] StRdAr = 3'd3;
  localparam logic [2:0] StRdR  = 3'd4;
  localparam logic [2:0] StRsp  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  cmd_ready_q, cmd_ready_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic                  bready_q, bready_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0]  wstrb_q, wstrb_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;

  logic aw_done;
  logic w_done;
  logic stall;
  logic timeout_set;

  // A channel counts as done once its valid has dropped or handshakes this cycle.
  assign aw_done = !awvalid_q || m_axi_lite.awready;
  assign w_done  = !wvalid_q || m_axi_lite.wready;

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready_q) begin
          cmd_ready_d = 1'b0;
          addr_d      = cmd_addr;
          wdata_d     = cmd_wdata;
          wstrb_d     = cmd_wstrb;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWr;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdAr;
          end
        end
      end
      StWr: begin
        if (awvalid_q && m_axi_lite.awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi_lite.wready)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          bready_d = 1'b1;
          state_d  = StWrB;
        end
      end
      StWrB: begin
        if (m_axi_lite.bvalid && bready_q) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = m_axi_lite.bresp;
          state_d     = StRsp;
        end
      end
      StRdAr: begin
        if (m_axi_lite.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdR;
        end
      end
      StRdR: begin
        if (m_axi_lite.rvalid && rready_q) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = m_axi_lite.rdata;
          rsp_resp_d  = m_axi_lite.rresp;
          state_d     = StRsp;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        // Unreachable encodings recover to a clean idle.
        state_d     = StIdle;
        cmd_ready_d = 1'b1;
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        bready_d    = 1'b0;
        arvalid_d   = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // Stall counter restarts on every state change and saturates at the limit;
  // the flag is set only on the step into the limit so a clear is not undone.
  always_comb begin
    stall       = (state_q == StWr) || (state_q == StWrB) ||
                  (state_q == StRdAr) || (state_q == StRdR);
    cnt_d       = cnt_q;
    timeout_set = 1'b0;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != CntMax)) begin
      cnt_d       = cnt_q + CntWidth'(1);
      timeout_set = (TIMEOUT_CYCLES != 0) && (cnt_q == CntSet);
    end
    if (timeout_set) begin
      timeout_d = 1'b1;
    end else if (timeout_clr) begin
      timeout_d = 1'b0;
    end else begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      cnt_q       <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign timeout   = timeout_q;

  assign m_axi_lite.awvalid = awvalid_q;
  assign m_axi_lite.awaddr  = addr_q;
  assign m_axi_lite.awprot  = 3'b000;
  assign m_axi_lite.wvalid  = wvalid_q;
  assign m_axi_lite.wdata   = wdata_q;
  assign m_axi_lite.wstrb   = wstrb_q;
  assign m_axi_lite.bready  = bready_q;
  assign m_axi_lite.arvalid = arvalid_q;
  assign m_axi_lite.araddr  = addr_q;
  assign m_axi_lite.arprot  = 3'b000;
  assign m_axi_lite.rready  = rready_q;

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// Bench for axi_lite_reg_master: memory-backed AXI4-Lite slave model with
// controllable stalls, and a queue of expected responses per command.
module tb_axi_lite_reg_master;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  typedef struct packed {
    logic          wr;
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout;
  logic          timeout_clr = 1'b0;

  // Slave controls
  logic          awready_en = 1'b1;
  logic          wready_en = 1'b1;
  logic          arready_en = 1'b1;
  logic          bvalid_en = 1'b1;
  logic          rd_force = 1'b0;
  logic [DW-1:0] rd_force_data = '0;
  logic [1:0]    rd_force_resp = '0;

  logic          s_bvalid, s_rvalid;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          aw_got, w_got;
  logic [AW-1:0] aw_addr_s;
  logic [DW-1:0] w_data_s;
  logic [SW-1:0] w_strb_s;
  logic [DW-1:0] mem [256];

  int   n_checks = 0;
  int   n_fail = 0;
  int   b_count = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  axi_lite_reg_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  axi_lite_reg_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .axi_aclk   (clk),
    .axi_resetn (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_write  (rsp_write),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .timeout    (timeout),
    .timeout_clr(timeout_clr),
    .m_axi_lite (bus)
  );

  assign bus.awready = awready_en;
  assign bus.wready  = wready_en;
  assign bus.arready = arready_en;
  assign bus.bvalid  = s_bvalid;
  assign bus.bresp   = 2'b00;
  assign bus.rvalid  = s_rvalid;
  assign bus.rdata   = s_rdata;
  assign bus.rresp   = s_rresp;

  always @(posedge clk or negedge rst_n) begin : slave
    logic          aw_hs, w_hs;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    if (!rst_n) begin
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      s_bvalid <= 1'b0;
      s_rvalid <= 1'b0;
      s_rdata  <= '0;
      s_rresp  <= '0;
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      aw_hs = bus.awvalid && bus.awready;
      w_hs  = bus.wvalid && bus.wready;
      if (aw_hs) begin
        aw_got    <= 1'b1;
        aw_addr_s <= bus.awaddr;
      end
      if (w_hs) begin
        w_got    <= 1'b1;
        w_data_s <= bus.wdata;
        w_strb_s <= bus.wstrb;
      end
      if ((aw_got || aw_hs) && (w_got || w_hs) && !s_bvalid && bvalid_en) begin
        a = aw_hs ? bus.awaddr : aw_addr_s;
        d = w_hs ? bus.wdata : w_data_s;
        s = w_hs ? bus.wstrb : w_strb_s;
        for (int b = 0; b < SW; b++) begin
          if (s[b]) mem[a[9:2]][8*b +: 8] <= d[8*b +: 8];
        end
        s_bvalid <= 1'b1;
        aw_got   <= 1'b0;
        w_got    <= 1'b0;
      end else if (s_bvalid && bus.bready) begin
        s_bvalid <= 1'b0;
      end
      if (bus.arvalid && bus.arready) begin
        s_rvalid <= 1'b1;
        s_rdata  <= rd_force ? rd_force_data : mem[bus.araddr[9:2]];
        s_rresp  <= rd_force ? rd_force_resp : 2'b00;
      end else if (s_rvalid && bus.rready) begin
        s_rvalid <= 1'b0;
      end
    end
  end

  always @(posedge clk) if (bus.bvalid && bus.bready) b_count++;

  // Present a command at a negedge, return at the negedge after acceptance.
  task automatic send_cmd(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [SW-1:0] s, input logic [DW-1:0] exp_rdata,
                          input logic [1:0] exp_resp);
    exp_t e;
    int   n;
    e.wr = wr; e.rdata = exp_rdata; e.resp = exp_resp;
    exp_q.push_back(e);
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      n_checks++; n_fail++;
      $display("FAIL cmd_accept: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp_valid(output int n);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rsp_valid) begin
      n_checks++; n_fail++;
      $display("FAIL rsp_wait: rsp_valid=%b after %0d cycles, required 1", rsp_valid, n);
    end
  endtask

  task automatic rsp_handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({cmd_ready, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
         rsp_valid, timeout} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b required 10000000",
               {cmd_ready, bus.awvalid, bus.wvalid, bus.bready, bus.arvalid, bus.rready,
                rsp_valid, timeout});
    end
    n_checks++;
    if ({bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.awprot, bus.arprot} !== '0) begin
      n_fail++;
      $display("FAIL reset_bus: got %h required 0",
               {bus.awaddr, bus.araddr, bus.wdata, bus.wstrb, bus.awprot, bus.arprot});
    end
    n_checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: got %h required 0", {rsp_write, rsp_rdata, rsp_resp});
    end
  endtask

  task automatic test_write_zero_wait();
    int   n;
    exp_t e;
    send_cmd(1'b1, 10'h000, 32'h0000_0001, 4'hF, '0, 2'b00);
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata, bus.wstrb} !==
        {2'b11, 10'h000, 32'h0000_0001, 4'hF}) begin
      n_fail++;
      $display("FAIL wr_issue: got %h required %h",
               {bus.awvalid, bus.wvalid, bus.awaddr, bus.wdata, bus.wstrb},
               {2'b11, 10'h000, 32'h0000_0001, 4'hF});
    end
    @(negedge clk);
    n_checks++;
    if ({bus.awvalid, bus.wvalid, bus.bready} !== 3'b001) begin
      n_fail++;
      $display("FAIL wr_same_cycle_hs: aw/w/bready=%b required 001",
               {bus.awvalid, bus.wvalid, bus.bready});
    end
    wait_rsp_valid(n);
    n_checks++;
    if (2 + n !== 3) begin
      n_fail++;
      $display("FAIL wr_latency: rsp_valid %0d cycles after accept, required 3", 2 + n);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
      n_fail++;
      $display("FAIL wr_payload: got %h required %h", {rsp_write, rsp_rdata, rsp_resp}, e);
    end
    rsp_handshake();
    n_checks++;
    if ({cmd_ready, rsp_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL wr_back_idle: cmd_ready/rsp_valid=%b required 10", {cmd_ready, rsp_valid});
    end
  endtask

  task automatic test_write_aw_delay();
    int   n, b0;
    logic aw_stable, w_dropped;
    exp_t e;
    awready_en = 1'b0;
    b0 = b_count;
    aw_stable = 1'b1;
    w_dropped = 1'b1;
    send_cmd(1'b1, 10'h010, 32'hCAFE_F00D, 4'h5, '0, 2'b00);
    for (int i = 1; i <= 5; i++) begin
      if (!(bus.awvalid && bus.awaddr == 10'h010)) aw_stable = 1'b0;
      if (i >= 2 && bus.wvalid) w_dropped = 1'b0;
      if (i == 5) awready_en = 1'b1;
      @(negedge clk);
    end
    n_checks++;
    if (aw_stable !== 1'b1) begin
      n_fail++;
      $display("FAIL aw_hold: awvalid/awaddr stable=%b required 1", aw_stable);
    end
    n_checks++;
    if (w_dropped !== 1'b1) begin
      n_fail++;
      $display("FAIL w_drop: wvalid low after its handshake=%b required 1", w_dropped);
    end
    wait_rsp_valid(n);
    e = exp_q.pop_front();
    n_checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
      n_fail++;
      $display("FAIL awdly_payload: got %h required %h", {rsp_write, rsp_rdata, rsp_resp}, e);
    end
    rsp_handshake();
    n_checks++;
    if (b_count - b0 !== 1) begin
      n_fail++;
      $display("FAIL awdly_bcount: B handshakes=%0d required 1", b_count - b0);
    end
  endtask

  task automatic test_read_slverr();
    int   n;
    exp_t e;
    rd_force = 1'b1; rd_force_data = 32'hDEAD_BEEF; rd_force_resp = 2'b10;
    send_cmd(1'b0, 10'h034, '0, '0, 32'hDEAD_BEEF, 2'b10);
    wait_rsp_valid(n);
    n_checks++;
    if (1 + n !== 3) begin
      n_fail++;
      $display("FAIL rd_latency: rsp_valid %0d cycles after accept, required 3", 1 + n);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
      n_fail++;
      $display("FAIL rd_payload: got %h required %h", {rsp_write, rsp_rdata, rsp_resp}, e);
    end
    rsp_handshake();
    rd_force = 1'b0;
  endtask

  task automatic test_rsp_stall();
    int          n;
    exp_t        e;
    logic        held;
    logic [34:0] snap;
    send_cmd(1'b0, 10'h010, '0, '0, 32'h00FE_000D, 2'b00);
    wait_rsp_valid(n);
    snap = {rsp_write, rsp_rdata, rsp_resp};
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (!rsp_valid || {rsp_write, rsp_rdata, rsp_resp} != snap || cmd_ready ||
          bus.awvalid || bus.wvalid || bus.bready || bus.arvalid || bus.rready) held = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (held !== 1'b1) begin
      n_fail++;
      $display("FAIL rsp_hold: response held with bus idle=%b required 1", held);
    end
    e = exp_q.pop_front();
    n_checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
      n_fail++;
      $display("FAIL stall_payload: got %h required %h", {rsp_write, rsp_rdata, rsp_resp}, e);
    end
    rsp_handshake();
  endtask

  task automatic test_timeout();
    int   n;
    logic stays_clear;
    exp_t e;
    arready_en = 1'b0;
    send_cmd(1'b0, 10'h020, '0, '0, 32'h0000_0000, 2'b00);
    for (int i = 0; i < 15; i++) @(negedge clk);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_early: timeout=%b after 15 stall cycles, required 0", timeout);
    end
    @(negedge clk);
    n_checks++;
    if ({timeout, bus.arvalid} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout_set: timeout/arvalid=%b after 16 stall cycles, required 11",
               {timeout, bus.arvalid});
    end
    timeout_clr = 1'b1;
    @(negedge clk);
    timeout_clr = 1'b0;
    stays_clear = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (timeout || !bus.arvalid) stays_clear = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (stays_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_clr: flag cleared with arvalid held=%b required 1", stays_clear);
    end
    arready_en = 1'b1;
    wait_rsp_valid(n);
    e = exp_q.pop_front();
    n_checks++;
    if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
      n_fail++;
      $display("FAIL late_ar_payload: got %h required %h", {rsp_write, rsp_rdata, rsp_resp}, e);
    end
    rsp_handshake();
  endtask

  task automatic test_reset_mid();
    int n;
    bvalid_en = 1'b0;
    send_cmd(1'b1, 10'h030, 32'hFFFF_FFFF, 4'hF, '0, 2'b00);
    void'(exp_q.pop_back());
    n = 0;
    while (!bus.bready && n < 50) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.bready, cmd_ready, bus.awvalid, bus.wvalid, rsp_valid} !== 5'b01000) begin
      n_fail++;
      $display("FAIL async_reset: bready/cmd_ready/awv/wv/rsp_valid=%b required 01000",
               {bus.bready, cmd_ready, bus.awvalid, bus.wvalid, rsp_valid});
    end
    bvalid_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if ({rsp_valid, cmd_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL reset_discard: rsp_valid/cmd_ready=%b required 01", {rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_back_to_back();
    rsp_ready = 1'b1;
    fork
      begin
        send_cmd(1'b1, 10'h030, 32'hA5A5_A5A5, 4'h3, '0, 2'b00);
        send_cmd(1'b0, 10'h030, '0, '0, 32'h0000_A5A5, 2'b00);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int   n;
          exp_t e;
          wait_rsp_valid(n);
          e = exp_q.pop_front();
          n_checks++;
          if ({rsp_write, rsp_rdata, rsp_resp} !== e) begin
            n_fail++;
            $display("FAIL b2b_payload_%0d: got %h required %h", k,
                     {rsp_write, rsp_rdata, rsp_resp}, e);
          end
          @(negedge clk);
        end
      end
    join
    rsp_ready = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_write_zero_wait();
    test_write_aw_delay();
    test_read_slverr();
    test_rsp_stall();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
